// File: rtl/sm_addsub_pipe.sv
// Two-stage pipelined sign-magnitude adder/subtractor with valid/ready handshake.
// Optional macro SM_ADDSUB_POS_ZERO_EN forces a positive sign on zero results.
module sm_addsub_pipe #(
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  sign_a,
    input  logic                  sign_b,
    input  logic                  symbol,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH:0]   out,
    output logic                  sign_out,
    output logic                  zero
);

    logic                  en_s;
    logic                  eff_sub_s;
    logic                  swap_s;
    logic [DATA_WIDTH-1:0] big_s;
    logic [DATA_WIDTH-1:0] small_s;

    logic                  v1_r;
    logic                  sub1_r;
    logic                  swap1_r;
    logic                  sign_a1_r;
    logic                  sign_beff1_r;
    logic [DATA_WIDTH-1:0] big1_r;
    logic [DATA_WIDTH-1:0] small1_r;

    logic [DATA_WIDTH:0]   res_s;
    logic                  res_zero_s;
    logic                  res_sign_s;

    logic                  out_valid_r;
    logic [DATA_WIDTH:0]   out_r;
    logic                  sign_out_r;
    logic                  zero_r;

    // Both stages move together whenever the output register is free or draining.
    assign en_s      = !out_valid_r || out_ready;
    assign in_ready  = !rst_n || en_s;
    assign out_valid = out_valid_r;
    assign out       = out_r;
    assign sign_out  = sign_out_r;
    assign zero      = zero_r;

    // Stage-1 decode: effective operation and magnitude ordering.
    always_comb begin
        eff_sub_s = sign_a ^ sign_b ^ symbol;
        swap_s    = (a < b);
        big_s     = swap_s ? b : a;
        small_s   = swap_s ? a : b;
    end

    // Stage-2 arithmetic on the ordered magnitudes, so subtraction never underflows.
    always_comb begin
        res_s      = sub1_r ? ({1'b0, big1_r} - {1'b0, small1_r})
                            : ({1'b0, big1_r} + {1'b0, small1_r});
        res_zero_s = (res_s == '0);
        res_sign_s = (sub1_r && swap1_r) ? sign_beff1_r : sign_a1_r;
`ifdef SM_ADDSUB_POS_ZERO_EN
        if (res_zero_s) begin
            res_sign_s = 1'b0;
        end else begin
            res_sign_s = res_sign_s;
        end
`endif
    end

    // Stage-1 register: captures the decoded operand set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_r         <= 1'b0;
            sub1_r       <= 1'b0;
            swap1_r      <= 1'b0;
            sign_a1_r    <= 1'b0;
            sign_beff1_r <= 1'b0;
            big1_r       <= '0;
            small1_r     <= '0;
        end else if (en_s) begin
            v1_r <= in_valid;
            if (in_valid) begin
                sub1_r       <= eff_sub_s;
                swap1_r      <= swap_s;
                sign_a1_r    <= sign_a;
                sign_beff1_r <= sign_b ^ symbol;
                big1_r       <= big_s;
                small1_r     <= small_s;
            end
        end
    end

    // Stage-2 register: result holds while stalled, bubbles clear out_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_r       <= '0;
            sign_out_r  <= 1'b0;
            zero_r      <= 1'b0;
        end else if (en_s) begin
            out_valid_r <= v1_r;
            if (v1_r) begin
                out_r      <= res_s;
                sign_out_r <= res_sign_s;
                zero_r     <= res_zero_s;
            end
        end
    end

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Self-checking bench for sm_addsub_pipe: directed table, stall/reset sequences,
// and randomized traffic against an integer-arithmetic reference model.
module tb_sm_addsub_pipe;

    localparam int DW = 24;
`ifdef SM_ADDSUB_POS_ZERO_EN
    localparam bit POS_ZERO = 1'b1;
`else
    localparam bit POS_ZERO = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          sa;
        logic          sb;
        logic          sym;
        logic [DW:0]   eo;
        logic          es;
        logic          ez;
    } vec_t;

    typedef struct {
        logic [DW:0] o;
        logic        s;
        logic        z;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic          sign_a = 1'b0;
    logic          sign_b = 1'b0;
    logic          symbol = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW:0]   out;
    logic          sign_out;
    logic          zero;

    int   n_cmp = 0;
    int   n_bad = 0;
    res_t exp_q[$];
    bit   prev_stall = 1'b0;
    res_t prev_res;

    sm_addsub_pipe #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sign_a(sign_a), .sign_b(sign_b), .symbol(symbol),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .sign_out(sign_out), .zero(zero)
    );

    always #5 clk = ~clk;

    function automatic res_t model(logic [DW-1:0] ma, logic [DW-1:0] mb,
                                   logic msa, logic msb, logic msym);
        longint va, vb, r;
        res_t   x;
        va = msa ? -longint'(ma) : longint'(ma);
        vb = msb ? -longint'(mb) : longint'(mb);
        r  = msym ? (va - vb) : (va + vb);
        x.o = (r < 0) ? (DW+1)'(-r) : (DW+1)'(r);
        x.z = (r == 0);
        if (r < 0)       x.s = 1'b1;
        else if (r > 0)  x.s = 1'b0;
        else             x.s = POS_ZERO ? 1'b0 : msa;
        return x;
    endfunction

    task automatic check(string name, longint act, longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // One clock: drive after the edge, evaluate handshakes at the falling edge.
    task automatic step(input logic rn, input logic iv, input logic [DW-1:0] ia,
                        input logic [DW-1:0] ib, input logic isa, input logic isb,
                        input logic isym, input logic ordy);
        res_t e;
        @(posedge clk);
        #1;
        rst_n = rn; in_valid = iv; a = ia; b = ib;
        sign_a = isa; sign_b = isb; symbol = isym; out_ready = ordy;
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_out",  out,      prev_res.o);
                check("stall_sign", sign_out, prev_res.s);
                check("stall_zero", zero,     prev_res.z);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_out",  out,      e.o);
                    check("sb_sign", sign_out, e.s);
                    check("sb_zero", zero,     e.z);
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(a, b, sign_a, sign_b, symbol));
            prev_stall = out_valid && !out_ready;
            prev_res.o = out; prev_res.s = sign_out; prev_res.z = zero;
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, ordy);
    endtask

    vec_t vecs[10];
    logic [DW-1:0] ra, rb;

    initial begin
        vecs[0] = '{24'd100,      24'd215,      1'b0, 1'b0, 1'b0, 25'd315,      1'b0, 1'b0};
        vecs[1] = '{24'd16777210, 24'd20,       1'b0, 1'b0, 1'b0, 25'd16777230, 1'b0, 1'b0};
        vecs[2] = '{24'd85,       24'd215,      1'b0, 1'b1, 1'b0, 25'd130,      1'b1, 1'b0};
        vecs[3] = '{24'd100,      24'd16777210, 1'b1, 1'b0, 1'b1, 25'd16777310, 1'b1, 1'b0};
        vecs[4] = '{24'd215,      24'd215,      1'b1, 1'b1, 1'b1, 25'd0,        !POS_ZERO, 1'b1};
        vecs[5] = '{24'd500,      24'd200,      1'b0, 1'b0, 1'b1, 25'd300,      1'b0, 1'b0};
        vecs[6] = '{24'd0,        24'd0,        1'b0, 1'b0, 1'b0, 25'd0,        1'b0, 1'b1};
        vecs[7] = '{24'd16777215, 24'd16777215, 1'b0, 1'b0, 1'b0, 25'd33554430, 1'b0, 1'b0};
        vecs[8] = '{24'd200,      24'd500,      1'b0, 1'b0, 1'b1, 25'd300,      1'b1, 1'b0};
        vecs[9] = '{24'd300,      24'd100,      1'b1, 1'b0, 1'b0, 25'd200,      1'b1, 1'b0};

        // Reset state.
        step(1'b0, 1'b1, 24'd5, 24'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_in_ready", in_ready, 1);
        idle(1'b1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out",       out,       0);
        check("rst_sign",      sign_out,  0);
        check("rst_zero",      zero,      0);
        check("rst_in_ready2", in_ready,  1);

        // Directed table, one operand set at a time, with latency check.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb, vecs[i].sym, 1'b1);
            idle(1'b1);
            check("lat_early_valid", out_valid, 0);
            idle(1'b1);
            check("lat_valid", out_valid, 1);
            check("vec_out",   out,       vecs[i].eo);
            check("vec_sign",  sign_out,  vecs[i].es);
            check("vec_zero",  zero,      vecs[i].ez);
        end
        idle(1'b1);

        // Back-to-back inputs with a three-cycle downstream stall.
        step(1'b1, 1'b1, 24'd1, 24'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 24'd10, 24'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 24'd7, 24'd9, 1'b1, 1'b0, 1'b0, 1'b0);
            check("stall_in_ready", in_ready, 0);
            check("stall_valid",    out_valid, 1);
            check("stall_first",    out, 3);
        end
        step(1'b1, 1'b1, 24'd7, 24'd9, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("stall_drained", exp_q.size(), 0);

        // Reset with two results in flight.
        step(1'b1, 1'b1, 24'd11, 24'd22, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 24'd33, 24'd44, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        check("mid_rst_valid", out_valid, 0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            check("post_rst_valid", out_valid, 0);
        end

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            ra = DW'($urandom);
            rb = DW'($urandom);
            case ($urandom_range(0, 5))
                0:       rb = ra;
                1:       ra = '1;
                2:       rb = '0;
                default: ;
            endcase
            step(1'b1, ($urandom_range(0, 3) != 0), ra, rb, 1'($urandom), 1'($urandom),
                 1'($urandom), ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1'b1);
        check("final_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
